// File: rtl/dmi_pkg.sv
// Shared DMI DBus field layout, op/response encodings and router FSM state type.
package dmi_pkg;

    localparam int unsigned ADDR_BITS = 7;
    localparam int unsigned DATA_BITS = 32;
    localparam int unsigned OP_BITS   = 2;

    localparam int unsigned OP_LSB    = 0;
    localparam int unsigned DATA_LSB  = OP_LSB + OP_BITS;
    localparam int unsigned ADDR_LSB  = DATA_LSB + DATA_BITS;

    localparam logic [OP_BITS-1:0] OP_NOP   = 2'd0;
    localparam logic [OP_BITS-1:0] OP_READ  = 2'd1;
    localparam logic [OP_BITS-1:0] OP_WRITE = 2'd2;

    localparam logic [OP_BITS-1:0] RESP_OK     = 2'd0;
    localparam logic [OP_BITS-1:0] RESP_FAILED = 2'd2;
    localparam logic [OP_BITS-1:0] RESP_BUSY   = 2'd3;

    typedef enum logic [1:0] {
        Q_IDLE = 2'd0,
        Q_REQ  = 2'd1,
        Q_RSP  = 2'd2,
        Q_OUT  = 2'd3
    } t_router_fsm;

endpackage

// File: rtl/dmi_addr_decode.sv
// Two-way DMI address decoder: DM0 below DM1_BASE, DM1 window rebased to 0, rest unmapped.
module dmi_addr_decode
    import dmi_pkg::*;
#(
    parameter logic [ADDR_BITS-1:0] DM1_BASE = 7'h40,
    parameter logic [ADDR_BITS-1:0] DM1_SIZE = 7'h30
) (
    input  logic [ADDR_BITS-1:0] addr,
    output logic                 sel,
    output logic                 unmapped,
    output logic [ADDR_BITS-1:0] rebased_addr
);

    // One extra bit so a window reaching the top of the address space cannot wrap.
    localparam logic [ADDR_BITS:0] DM1_END = {1'b0, DM1_BASE} + {1'b0, DM1_SIZE};

    always_comb begin
        sel          = 1'b0;
        unmapped     = 1'b0;
        rebased_addr = addr;
        if ({1'b0, addr} >= DM1_END) begin
            unmapped = 1'b1;
        end else if (addr >= DM1_BASE) begin
            sel          = 1'b1;
            rebased_addr = addr - DM1_BASE;
        end
    end

endmodule

// File: rtl/dmi_router.sv
// Routes one DTM DBus port to two Debug Modules by address, one transaction at a time.
// Optional response timeout with late-response draining: define DMI_ROUTER_TIMEOUT_EN.
module dmi_router
    import dmi_pkg::*;
#(
    parameter int unsigned          DBUS_REQ_BITS  = 41,
    parameter int unsigned          DBUS_RSP_BITS  = 34,
    parameter logic [ADDR_BITS-1:0] DM1_BASE       = 7'h40,
    parameter logic [ADDR_BITS-1:0] DM1_SIZE       = 7'h30,
    parameter int unsigned          TIMEOUT_CYCLES = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     dtm_req_vld,
    output logic                     dtm_req_rdy,
    input  logic [DBUS_REQ_BITS-1:0] dtm_req_bits,
    output logic                     dtm_rsp_vld,
    input  logic                     dtm_rsp_rdy,
    output logic [DBUS_RSP_BITS-1:0] dtm_rsp_bits,
    output logic                     dm0_req_vld,
    input  logic                     dm0_req_rdy,
    output logic [DBUS_REQ_BITS-1:0] dm0_req_bits,
    input  logic                     dm0_rsp_vld,
    output logic                     dm0_rsp_rdy,
    input  logic [DBUS_RSP_BITS-1:0] dm0_rsp_bits,
    output logic                     dm1_req_vld,
    input  logic                     dm1_req_rdy,
    output logic [DBUS_REQ_BITS-1:0] dm1_req_bits,
    input  logic                     dm1_rsp_vld,
    output logic                     dm1_rsp_rdy,
    input  logic [DBUS_RSP_BITS-1:0] dm1_rsp_bits
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("dmi_router: TIMEOUT_CYCLES must be at least 1");
    end

    t_router_fsm          state;
    t_router_fsm          state_nxt;
    logic                 sel;
    logic                 dec_sel;
    logic                 dec_unmapped;
    logic [ADDR_BITS-1:0] dec_addr;
    logic                 accept;
    logic                 req_done;
    logic                 rsp_take;
    logic                 out_done;
    logic                 timeout;
    logic [1:0]           drain;

    dmi_addr_decode #(
        .DM1_BASE (DM1_BASE),
        .DM1_SIZE (DM1_SIZE)
    ) u_decode (
        .addr         (dtm_req_bits[ADDR_LSB +: ADDR_BITS]),
        .sel          (dec_sel),
        .unmapped     (dec_unmapped),
        .rebased_addr (dec_addr)
    );

    assign accept   = dtm_req_vld && (state == Q_IDLE);
    assign req_done = sel ? (dm1_req_vld && dm1_req_rdy) : (dm0_req_vld && dm0_req_rdy);
    assign rsp_take = (state == Q_RSP) && (sel ? dm1_rsp_vld : dm0_rsp_vld);
    assign out_done = dtm_rsp_vld && dtm_rsp_rdy;

`ifdef DMI_ROUTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    assign timeout = (state == Q_RSP) && !rsp_take &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // A timed-out DM is drained: its next response is accepted and dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            drain    <= '0;
        end else begin
            if (state == Q_RSP) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (timeout && !sel) begin
                drain[0] <= 1'b1;
            end else if (drain[0] && dm0_rsp_vld) begin
                drain[0] <= 1'b0;
            end
            if (timeout && sel) begin
                drain[1] <= 1'b1;
            end else if (drain[1] && dm1_rsp_vld) begin
                drain[1] <= 1'b0;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign drain   = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= Q_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        dtm_req_rdy = (state == Q_IDLE);
        dm0_rsp_rdy = ((state == Q_RSP) && !sel) || drain[0];
        dm1_rsp_rdy = ((state == Q_RSP) &&  sel) || drain[1];
        case (state)
            Q_IDLE: if (accept) state_nxt = dec_unmapped ? Q_OUT : Q_REQ;
            Q_REQ:  if (req_done) state_nxt = Q_RSP;
            Q_RSP:  if (rsp_take || timeout) state_nxt = Q_OUT;
            Q_OUT:  if (out_done) state_nxt = Q_IDLE;
            default: state_nxt = Q_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel          <= 1'b0;
            dm0_req_vld  <= 1'b0;
            dm0_req_bits <= '0;
            dm1_req_vld  <= 1'b0;
            dm1_req_bits <= '0;
            dtm_rsp_vld  <= 1'b0;
            dtm_rsp_bits <= '0;
        end else begin
            if (accept) begin
                sel <= dec_sel;
                if (dec_unmapped) begin
                    dtm_rsp_bits <= {{DATA_BITS{1'b0}}, RESP_FAILED};
                    dtm_rsp_vld  <= 1'b1;
                end else if (dec_sel) begin
                    dm1_req_bits <= {dec_addr, dtm_req_bits[ADDR_LSB-1:0]};
                    dm1_req_vld  <= !drain[1];
                end else begin
                    dm0_req_bits <= dtm_req_bits;
                    dm0_req_vld  <= !drain[0];
                end
            end

            // A request parked behind a draining DM launches once the drain clears.
            if (req_done) begin
                dm0_req_vld <= 1'b0;
                dm1_req_vld <= 1'b0;
            end else if (state == Q_REQ) begin
                if (!sel && !drain[0]) dm0_req_vld <= 1'b1;
                if ( sel && !drain[1]) dm1_req_vld <= 1'b1;
            end

            if (rsp_take) begin
                dtm_rsp_bits <= sel ? dm1_rsp_bits : dm0_rsp_bits;
                dtm_rsp_vld  <= 1'b1;
            end else if (timeout) begin
                dtm_rsp_bits <= {{DATA_BITS{1'b0}}, RESP_BUSY};
                dtm_rsp_vld  <= 1'b1;
            end else if (out_done) begin
                dtm_rsp_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmi_router.sv
// Directed self-checking bench for dmi_router (default build, 41/34-bit DBus, DM1 at 0x40..0x6F).
module tb_dmi_router;
    timeunit 1ns;
    timeprecision 1ps;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dtm_req_vld;
    logic        dtm_req_rdy;
    logic [40:0] dtm_req_bits;
    logic        dtm_rsp_vld;
    logic        dtm_rsp_rdy;
    logic [33:0] dtm_rsp_bits;
    logic        dm0_req_vld, dm0_req_rdy;
    logic [40:0] dm0_req_bits;
    logic        dm0_rsp_vld, dm0_rsp_rdy;
    logic [33:0] dm0_rsp_bits;
    logic        dm1_req_vld, dm1_req_rdy;
    logic [40:0] dm1_req_bits;
    logic        dm1_rsp_vld, dm1_rsp_rdy;
    logic [33:0] dm1_rsp_bits;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    dmi_router #(
        .DBUS_REQ_BITS  (41),
        .DBUS_RSP_BITS  (34),
        .DM1_BASE       (7'h40),
        .DM1_SIZE       (7'h30),
        .TIMEOUT_CYCLES (256)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dtm_req_vld  (dtm_req_vld),
        .dtm_req_rdy  (dtm_req_rdy),
        .dtm_req_bits (dtm_req_bits),
        .dtm_rsp_vld  (dtm_rsp_vld),
        .dtm_rsp_rdy  (dtm_rsp_rdy),
        .dtm_rsp_bits (dtm_rsp_bits),
        .dm0_req_vld  (dm0_req_vld),
        .dm0_req_rdy  (dm0_req_rdy),
        .dm0_req_bits (dm0_req_bits),
        .dm0_rsp_vld  (dm0_rsp_vld),
        .dm0_rsp_rdy  (dm0_rsp_rdy),
        .dm0_rsp_bits (dm0_rsp_bits),
        .dm1_req_vld  (dm1_req_vld),
        .dm1_req_rdy  (dm1_req_rdy),
        .dm1_req_bits (dm1_req_bits),
        .dm1_rsp_vld  (dm1_rsp_vld),
        .dm1_rsp_rdy  (dm1_rsp_rdy),
        .dm1_rsp_bits (dm1_rsp_bits)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Full transaction with ready DMs; route 0/1 = DM0/DM1, 2 = unmapped.
    task automatic run_txn(input string tag, input logic [6:0] addr, input logic [31:0] data,
                           input logic [1:0] op, input int route, input logic [6:0] exp_addr,
                           input logic [33:0] rsp);
        logic [40:0] exp_req;
        exp_req      = {exp_addr, data, op};
        dtm_req_bits = {addr, data, op};
        dtm_req_vld  = 1'b1;
        tick();
        dtm_req_vld = 1'b0;
        if (route == 2) begin
            check({tag, "_unm_vld"}, 64'(dtm_rsp_vld), 64'h1);
            check({tag, "_unm_bits"}, 64'(dtm_rsp_bits), 64'h2);
            check({tag, "_unm_dm_idle"}, 64'({dm0_req_vld, dm1_req_vld}), 64'h0);
        end else begin
            check({tag, "_req_vld"}, 64'({dm1_req_vld, dm0_req_vld}), (route == 1) ? 64'h2 : 64'h1);
            check({tag, "_req_bits"}, 64'((route == 1) ? dm1_req_bits : dm0_req_bits), 64'(exp_req));
            tick();
            check({tag, "_rsp_rdy"}, 64'({dm1_rsp_rdy, dm0_rsp_rdy}), (route == 1) ? 64'h2 : 64'h1);
            if (route == 1) begin
                dm1_rsp_bits = rsp;
                dm1_rsp_vld  = 1'b1;
            end else begin
                dm0_rsp_bits = rsp;
                dm0_rsp_vld  = 1'b1;
            end
            tick();
            dm0_rsp_vld = 1'b0;
            dm1_rsp_vld = 1'b0;
            check({tag, "_dtm_vld"}, 64'(dtm_rsp_vld), 64'h1);
            check({tag, "_dtm_bits"}, 64'(dtm_rsp_bits), 64'(rsp));
        end
        dtm_rsp_rdy = 1'b1;
        tick();
        dtm_rsp_rdy = 1'b0;
        check({tag, "_done"}, 64'({dtm_rsp_vld, dtm_req_rdy}), 64'h1);
    endtask

    initial begin
        rst_n        = 1'b0;
        dtm_req_vld  = 1'b0;
        dtm_req_bits = '0;
        dtm_rsp_rdy  = 1'b0;
        dm0_req_rdy  = 1'b0;
        dm0_rsp_vld  = 1'b0;
        dm0_rsp_bits = '0;
        dm1_req_rdy  = 1'b0;
        dm1_rsp_vld  = 1'b0;
        dm1_rsp_bits = '0;
        tick();
        tick();
        check("rst_vld", 64'({dtm_rsp_vld, dm0_req_vld, dm1_req_vld}), 64'h0);
        check("rst_bits", 64'(dm0_req_bits | dm1_req_bits | 41'(dtm_rsp_bits)), 64'h0);
        check("rst_rdy", 64'({dtm_req_rdy, dm0_rsp_rdy, dm1_rsp_rdy}), 64'h4);
        rst_n = 1'b1;
        tick();

        // Read to DM0, DM0 request ready held low for one cycle.
        dtm_req_bits = {7'h11, 32'h0, 2'd1};
        dtm_req_vld  = 1'b1;
        tick();
        dtm_req_vld = 1'b0;
        check("rd_dm0_vld", 64'(dm0_req_vld), 64'h1);
        check("rd_dm0_bits", 64'(dm0_req_bits), 64'({7'h11, 32'h0, 2'd1}));
        check("rd_req_rdy_low", 64'(dtm_req_rdy), 64'h0);
        dm0_req_rdy = 1'b1;
        tick();
        check("rd_dm0_vld_clr", 64'(dm0_req_vld), 64'h0);
        check("rd_dm0_rsp_rdy", 64'(dm0_rsp_rdy), 64'h1);
        dm0_rsp_bits = {32'hCAFE0001, 2'b00};
        dm0_rsp_vld  = 1'b1;
        tick();
        dm0_rsp_vld = 1'b0;
        check("rd_dtm_vld", 64'(dtm_rsp_vld), 64'h1);
        check("rd_dtm_bits", 64'(dtm_rsp_bits), 64'({32'hCAFE0001, 2'b00}));
        check("rd_dm0_rsp_rdy_off", 64'(dm0_rsp_rdy), 64'h0);
        dtm_rsp_rdy = 1'b1;
        tick();
        dtm_rsp_rdy = 1'b0;
        check("rd_done", 64'({dtm_rsp_vld, dtm_req_rdy}), 64'h1);

        // Write to DM1 with stalled DM1 request, spurious DM0 response and stalled DTM.
        dm1_req_rdy  = 1'b0;
        dm0_rsp_bits = {32'hDEADDEAD, 2'b00};
        dm0_rsp_vld  = 1'b1;
        dtm_req_bits = {7'h50, 32'h1234, 2'd2};
        dtm_req_vld  = 1'b1;
        tick();
        dtm_req_vld = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("wr_dm1_vld_hold", 64'({dm1_req_vld, dm0_req_vld}), 64'h2);
            check("wr_dm1_bits_hold", 64'(dm1_req_bits), 64'({7'h10, 32'h1234, 2'd2}));
            check("wr_req_rdy_low", 64'(dtm_req_rdy), 64'h0);
            tick();
        end
        dm1_req_rdy = 1'b1;
        tick();
        check("wr_dm1_vld_clr", 64'({dm1_req_vld, dm0_req_vld}), 64'h0);
        check("wr_rsp_rdy_sel", 64'({dm1_rsp_rdy, dm0_rsp_rdy}), 64'h2);
        dm1_rsp_bits = {32'hBEEF0002, 2'b00};
        dm1_rsp_vld  = 1'b1;
        tick();
        dm1_rsp_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("wr_dtm_vld_hold", 64'(dtm_rsp_vld), 64'h1);
            check("wr_dtm_bits_hold", 64'(dtm_rsp_bits), 64'({32'hBEEF0002, 2'b00}));
            check("wr_stray_rdy", 64'({dtm_req_rdy, dm0_rsp_rdy}), 64'h0);
            tick();
        end
        dtm_rsp_rdy = 1'b1;
        tick();
        dtm_rsp_rdy = 1'b0;
        dm0_rsp_vld = 1'b0;
        check("wr_done", 64'({dtm_rsp_vld, dtm_req_rdy}), 64'h1);

        // Unmapped and window boundaries.
        run_txn("unm70", 7'h70, 32'h5555, 2'd1, 2, 7'h00, 34'h0);
        run_txn("unm7f", 7'h7F, 32'h0, 2'd2, 2, 7'h00, 34'h0);
        run_txn("b3f", 7'h3F, 32'hA5A5A5A5, 2'd1, 0, 7'h3F, {32'h0000003F, 2'b00});
        run_txn("b40", 7'h40, 32'h00000040, 2'd2, 1, 7'h00, {32'h11112222, 2'b00});
        run_txn("b6f", 7'h6F, 32'hFFFFFFFF, 2'd1, 1, 7'h2F, {32'h87654321, 2'b10});
        run_txn("nop", 7'h05, 32'h0, 2'd0, 0, 7'h05, {32'h0, 2'b00});

        // Reset while a DM0 request is pending.
        dm0_req_rdy  = 1'b0;
        dtm_req_bits = {7'h22, 32'h77, 2'd1};
        dtm_req_vld  = 1'b1;
        tick();
        dtm_req_vld = 1'b0;
        check("mid_dm0_vld", 64'(dm0_req_vld), 64'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_vld", 64'({dtm_rsp_vld, dm0_req_vld, dm1_req_vld}), 64'h0);
        check("mid_rst_rdy", 64'({dtm_req_rdy, dm0_rsp_rdy}), 64'h2);
        check("mid_rst_bits", 64'(dm0_req_bits), 64'h0);
        dm0_req_rdy = 1'b1;
        tick();
        check("post_rst_quiet", 64'({dtm_rsp_vld, dm0_req_vld}), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
